h_alpha_streamer: RTL and testbench

Source-side feeder for the M-generation datapath. Holds one channel realisation in two on-chip buffers: an I-row H matrix and I alpha columns. On a start pulse it replays them as the `H_row`/`H_row_tvalid` stream, then the `alpha_u_col`/`alpha_u_col_tvalid`/`alpha_u_col_tlast` stream, in the order and framing the candidate/F evaluation pipeline consumes. The streams have no backpressure; pacing is set by a fixed inter-beat gap.

---
 rtl/h_alpha_streamer.sv | 169 ++++++++++++++++
 tb/tb_h_alpha_streamer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/h_alpha_streamer.sv
`default_nettype none
// ============================================================================
// Module   : h_alpha_streamer
// Brief    : Buffers one H matrix and one set of alpha columns, then replays
//            them as paced H-row and alpha-column streams on a start pulse.
// Revision : 1.0
// ============================================================================
module h_alpha_streamer #(
    parameter  int J   = 14,
    parameter  int I   = 7,
    parameter  int GAP = 0,
    localparam int AW  = (I > 1) ? $clog2(I) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cfg_we,
    input  logic            cfg_sel,
    input  logic [AW-1:0]   cfg_addr,
    input  logic [J*64-1:0] cfg_wdata,
    input  logic            start,
    output logic [J*64-1:0] H_row,
    output logic            H_row_tvalid,
    output logic [J*64-1:0] alpha_u_col,
    output logic            alpha_u_col_tvalid,
    output logic            alpha_u_col_tlast,
    output logic            busy,
    output logic            done,
    output logic            cfg_err
);

    localparam int              DW     = J * 64;
    localparam int              GW     = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [AW-1:0]   c_LAST = AW'(I - 1);
    localparam logic [GW-1:0]   c_GAP  = GW'(GAP);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEND_H = 2'd1,
        S_SEND_A = 2'd2,
        S_FIN    = 2'd3
    } state_t;

    state_t          r_state;
    logic [AW-1:0]   r_idx;
    logic [GW-1:0]   r_gcnt;
    logic            r_tail;
    logic [DW-1:0]   r_hbuf [I];
    logic [DW-1:0]   r_abuf [I];
    logic [DW-1:0]   r_hdat;
    logic [DW-1:0]   r_adat;
    logic            r_hv;
    logic            r_av;
    logic            r_tlast;
    logic            r_busy;
    logic            r_done;
    logic            r_err;

    logic            w_wr_ok;
    logic            w_wr_bad;
    logic [DW-1:0]   w_h0;

    assign w_wr_ok  = cfg_we && (r_state == S_IDLE) && (cfg_addr <= c_LAST);
    assign w_wr_bad = cfg_we && !w_wr_ok;
    // The first beat leaves on the start edge, so a same-cycle H[0] write is forwarded.
    assign w_h0     = (w_wr_ok && !cfg_sel && (cfg_addr == '0)) ? cfg_wdata : r_hbuf[0];

    always_ff @(posedge clk) begin
        if (rst_n && w_wr_ok) begin
            if (cfg_sel) begin
                r_abuf[cfg_addr] <= cfg_wdata;
            end else begin
                r_hbuf[cfg_addr] <= cfg_wdata;
            end
        end
    end

    // r_idx holds the index of the next beat; r_tail marks that the last alpha beat is out.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_gcnt  <= '0;
            r_tail  <= 1'b0;
            r_hdat  <= '0;
            r_adat  <= '0;
            r_hv    <= 1'b0;
            r_av    <= 1'b0;
            r_tlast <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_hdat  <= '0;
            r_adat  <= '0;
            r_hv    <= 1'b0;
            r_av    <= 1'b0;
            r_tlast <= 1'b0;
            r_done  <= 1'b0;
            if (w_wr_bad) begin
                r_err <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_hdat  <= w_h0;
                        r_hv    <= 1'b1;
                        r_busy  <= 1'b1;
                        r_gcnt  <= c_GAP;
                        r_tail  <= 1'b0;
                        r_idx   <= (c_LAST == '0) ? '0 : AW'(1);
                        r_state <= (c_LAST == '0) ? S_SEND_A : S_SEND_H;
                    end
                end
                S_SEND_H: begin
                    if (r_gcnt != '0) begin
                        r_gcnt <= r_gcnt - GW'(1);
                    end else begin
                        r_hdat <= r_hbuf[r_idx];
                        r_hv   <= 1'b1;
                        r_gcnt <= c_GAP;
                        if (r_idx == c_LAST) begin
                            r_idx   <= '0;
                            r_state <= S_SEND_A;
                        end else begin
                            r_idx <= r_idx + AW'(1);
                        end
                    end
                end
                S_SEND_A: begin
                    if (r_tail) begin
                        r_tail  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_FIN;
                    end else if (r_gcnt != '0) begin
                        r_gcnt <= r_gcnt - GW'(1);
                    end else begin
                        r_adat <= r_abuf[r_idx];
                        r_av   <= 1'b1;
                        if (r_idx == c_LAST) begin
                            r_tlast <= 1'b1;
                            r_tail  <= 1'b1;
                            r_gcnt  <= '0;
                        end else begin
                            r_idx  <= r_idx + AW'(1);
                            r_gcnt <= c_GAP;
                        end
                    end
                end
                S_FIN: begin
                    r_busy  <= 1'b0;
                    r_idx   <= '0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign H_row              = r_hdat;
    assign H_row_tvalid       = r_hv;
    assign alpha_u_col        = r_adat;
    assign alpha_u_col_tvalid = r_av;
    assign alpha_u_col_tlast  = r_tlast;
    assign busy               = r_busy;
    assign done               = r_done;
    assign cfg_err            = r_err;

endmodule
`default_nettype wire

// File: tb/tb_h_alpha_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_h_alpha_streamer
// Brief    : Drives GAP=0 and GAP=2 streamers side by side against a
//            frame-schedule reference model.
// Revision : 1.0
// ============================================================================
module tb_h_alpha_streamer;

    localparam int NI = 7;
    localparam int NJ = 14;
    typedef logic [NJ*64-1:0] row_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_we;
    logic       cfg_sel;
    logic [2:0] cfg_addr;
    row_t       cfg_wdata;
    logic       start;

    row_t h0, a0, h1, a1;
    logic hv0, av0, tl0, bz0, dn0, er0;
    logic hv1, av1, tl1, bz1, dn1, er1;

    always #5 clk = ~clk;

    h_alpha_streamer #(.J(NJ), .I(NI), .GAP(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
        .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .start(start),
        .H_row(h0), .H_row_tvalid(hv0), .alpha_u_col(a0),
        .alpha_u_col_tvalid(av0), .alpha_u_col_tlast(tl0),
        .busy(bz0), .done(dn0), .cfg_err(er0)
    );

    h_alpha_streamer #(.J(NJ), .I(NI), .GAP(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
        .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .start(start),
        .H_row(h1), .H_row_tvalid(hv1), .alpha_u_col(a1),
        .alpha_u_col_tvalid(av1), .alpha_u_col_tlast(tl1),
        .busy(bz1), .done(dn1), .cfg_err(er1)
    );

    // Reference model: buffer images plus the edge number at which each frame started.
    int     gap_of [2] = '{0, 2};
    row_t   mh [2][NI];
    row_t   ma [2][NI];
    bit     m_act [2];
    longint m_ts [2];
    bit     m_err [2];
    longint edge_n = 0;

    row_t   e_h [2];
    row_t   e_a [2];
    bit     e_hv [2], e_av [2], e_tl [2], e_bz [2], e_dn [2], e_er [2];

    int n_vec = 0;
    int n_err = 0;

    task automatic model_step();
        edge_n++;
        for (int d = 0; d < 2; d++) begin
            longint per, last, k;
            bit     idle;
            per = longint'(gap_of[d] + 1);
            e_h[d] = '0; e_a[d] = '0;
            e_hv[d] = 0; e_av[d] = 0; e_tl[d] = 0; e_bz[d] = 0; e_dn[d] = 0;
            if (!rst_n) begin
                m_act[d] = 0;
                m_err[d] = 0;
            end else begin
                last = m_ts[d] + (2 * NI - 1) * per;
                idle = !m_act[d] || (edge_n >= last + 3);
                if (cfg_we) begin
                    if (idle && int'(cfg_addr) < NI) begin
                        if (cfg_sel) ma[d][cfg_addr] = cfg_wdata;
                        else         mh[d][cfg_addr] = cfg_wdata;
                    end else begin
                        m_err[d] = 1;
                    end
                end
                if (idle && start) begin
                    m_act[d] = 1;
                    m_ts[d]  = edge_n;
                    last     = m_ts[d] + (2 * NI - 1) * per;
                end
                if (m_act[d]) begin
                    k = edge_n - m_ts[d];
                    e_bz[d] = (edge_n <= last + 1);
                    e_dn[d] = (edge_n == last + 1);
                    if ((k % per) == 0 && (k / per) < 2 * NI) begin
                        if ((k / per) < NI) begin
                            e_hv[d] = 1;
                            e_h[d]  = mh[d][int'(k / per)];
                        end else begin
                            e_av[d] = 1;
                            e_a[d]  = ma[d][int'(k / per) - NI];
                            e_tl[d] = ((k / per) == 2 * NI - 1);
                        end
                    end
                end
            end
            e_er[d] = m_err[d];
        end
    endtask

    task automatic check_one(input int d, input row_t h, input row_t a,
                             input logic hv, input logic av, input logic tl,
                             input logic bz, input logic dn, input logic er);
        n_vec++;
        assert (h === e_h[d]) else begin
            n_err++;
            $error("FAIL g%0d H_row edge %0d: got low64 %h need low64 %h", gap_of[d], edge_n, h[63:0], e_h[d][63:0]);
        end
        n_vec++;
        assert (a === e_a[d]) else begin
            n_err++;
            $error("FAIL g%0d alpha_u_col edge %0d: got low64 %h need low64 %h", gap_of[d], edge_n, a[63:0], e_a[d][63:0]);
        end
        n_vec++;
        assert (hv === e_hv[d]) else begin
            n_err++;
            $error("FAIL g%0d H_row_tvalid edge %0d: got %b need %b", gap_of[d], edge_n, hv, e_hv[d]);
        end
        n_vec++;
        assert (av === e_av[d]) else begin
            n_err++;
            $error("FAIL g%0d alpha_tvalid edge %0d: got %b need %b", gap_of[d], edge_n, av, e_av[d]);
        end
        n_vec++;
        assert (tl === e_tl[d]) else begin
            n_err++;
            $error("FAIL g%0d alpha_tlast edge %0d: got %b need %b", gap_of[d], edge_n, tl, e_tl[d]);
        end
        n_vec++;
        assert (bz === e_bz[d]) else begin
            n_err++;
            $error("FAIL g%0d busy edge %0d: got %b need %b", gap_of[d], edge_n, bz, e_bz[d]);
        end
        n_vec++;
        assert (dn === e_dn[d]) else begin
            n_err++;
            $error("FAIL g%0d done edge %0d: got %b need %b", gap_of[d], edge_n, dn, e_dn[d]);
        end
        n_vec++;
        assert (er === e_er[d]) else begin
            n_err++;
            $error("FAIL g%0d cfg_err edge %0d: got %b need %b", gap_of[d], edge_n, er, e_er[d]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_one(0, h0, a0, hv0, av0, tl0, bz0, dn0, er0);
        check_one(1, h1, a1, hv1, av1, tl1, bz1, dn1, er1);
    endtask

    task automatic idle_n(input int n);
        repeat (n) tick();
    endtask

    task automatic wr(input logic sel, input logic [2:0] addr, input row_t data);
        cfg_we = 1'b1; cfg_sel = sel; cfg_addr = addr; cfg_wdata = data;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    function automatic row_t rand_row();
        row_t r;
        for (int i = 0; i < NJ * 2; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_act[d] = 0; m_ts[d] = 0; m_err[d] = 0;
            for (int r = 0; r < NI; r++) begin
                mh[d][r] = '0; ma[d][r] = '0;
            end
        end
        rst_n = 1'b0; cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = '0;
        cfg_wdata = '0; start = 1'b0;
        idle_n(3);
        rst_n = 1'b1;
        idle_n(2);

        // Patterned load, then a frame seen at both GAP settings.
        for (int r = 0; r < NI; r++) begin
            wr(1'b0, 3'(r), {NJ{64'(r + 1)}});
            wr(1'b1, 3'(r), {NJ{64'(r + 16)}});
        end
        pulse_start();
        idle_n(45);

        // Random contents; a write during SEND_H is rejected and start is re-pulsed mid-frame.
        for (int r = 0; r < NI; r++) begin
            wr(1'b0, 3'(r), rand_row());
            wr(1'b1, 3'(r), rand_row());
        end
        pulse_start();
        idle_n(3);
        wr(1'b0, 3'd2, rand_row());
        idle_n(2);
        pulse_start();
        idle_n(45);

        // Reset clears the error; an out-of-range address sets it again.
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        wr(1'b1, 3'd7, rand_row());
        wr(1'b0, 3'd7, rand_row());
        idle_n(2);
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();

        // Start together with a write of H[0].
        cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = 3'd0; cfg_wdata = {NJ{64'hAA}};
        start = 1'b1;
        tick();
        cfg_we = 1'b0; start = 1'b0;
        idle_n(45);

        // Mid-frame reset at beat 9, then a clean replay of retained buffers.
        pulse_start();
        idle_n(8);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        idle_n(2);
        pulse_start();
        idle_n(45);

        // Back-to-back frames: GAP=0 timing, then GAP=2 timing.
        pulse_start();
        idle_n(15);
        pulse_start();
        idle_n(45);
        pulse_start();
        idle_n(41);
        pulse_start();
        idle_n(45);

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            cfg_we    = ($urandom_range(0, 7) == 0);
            cfg_sel   = 1'($urandom_range(0, 1));
            cfg_addr  = 3'($urandom_range(0, 7));
            cfg_wdata = rand_row();
            start     = ($urandom_range(0, 19) == 0);
            rst_n     = ($urandom_range(0, 99) != 0);
            tick();
        end
        cfg_we = 1'b0; start = 1'b0; rst_n = 1'b1;
        idle_n(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
